// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB4 requester and its testbench.
package apb_pkg;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 32;
    localparam int APB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// Command/response handshake plus APB4 bus, seen from the requester (master)
// or from the command source and slave side (slave).
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [DATA_WIDTH-1:0]   cmd_wdata;
    logic [DATA_WIDTH/8-1:0] cmd_strb;

    logic                    rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// Counts stalled ACCESS cycles; o_hit flags the stall that reaches TIMEOUT.
module apb_timeout_counter
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Hit is combinational so the abort lands on the same edge as the TIMEOUT-th stall.
    assign o_hit = i_en && (r_cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// APB4 requester: one command at a time through IDLE -> SETUP -> ACCESS.
// Optional ACCESS watchdog is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = APB_TIMEOUT
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_state_e              r_state;
    apb_state_e              w_next;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_abort;

    logic                    r_cmd_ready;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [STRB_WIDTH-1:0]   r_pstrb;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_timeout;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_to_clear;
    logic w_to_en;

    assign w_to_clear = (r_state == SETUP);
    assign w_to_en    = (r_state == ACCESS) && !bus.PREADY;

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_clear (w_to_clear),
        .i_en    (w_to_en),
        .o_hit   (w_abort)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_abort          = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cmd_ready && bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = SETUP;
                end
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                // A completing PREADY beats a timeout hit on the same edge.
                if (bus.PREADY) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end else if (w_abort) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == IDLE);
            r_psel      <= (w_next != IDLE);
            r_penable   <= (w_next == ACCESS);
            r_rsp_valid <= w_done || w_abort;
            // Bus fields are loaded only on accept so they hold through ACCESS and IDLE.
            if (w_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
                r_pstrb  <= bus.cmd_write ? bus.cmd_strb  : '0;
            end
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_rsp_err     <= bus.PSLVERR;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PADDR       = r_paddr;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSTRB       = r_pstrb;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: the bench plays command source and APB slave.
module tb_apb_master;
    import apb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int       obs_lat;
    int       obs_acc;
    apb_rsp_t obs_rsp;
    logic     obs_accepted;
    logic     obs_setup_ok;
    logic     obs_stable_ok;
    logic     obs_busy_ready;
    logic     obs_rdy_at_rsp;

    always #5 clk = ~clk;

    apb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    apb_master #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .TIMEOUT    (16)
    ) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    // Junk slave values outside ACCESS; the requester must ignore them.
    task automatic idle_slave();
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hA5A5_A5A5;
    endtask

    // Issues one command, answers as a slave after 'waits' stall cycles and records what it saw.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int waits, input logic slverr,
                        input logic [31:0] rdata, input int limit);
        logic [31:0] ewd;
        logic [3:0]  est;
        int          acc;
        ewd = wr ? wdata : 32'h0;
        est = wr ? strb : 4'h0;
        obs_lat = -1; obs_acc = 0; obs_rsp = '0; obs_accepted = 1'b0;
        obs_setup_ok = 1'b0; obs_stable_ok = 1'b1; obs_busy_ready = 1'b0; obs_rdy_at_rsp = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = wdata; bus.cmd_strb = strb;
        for (int i = 0; i < 20 && !obs_accepted; i++) begin
            @(negedge clk);
            if (bus.cmd_ready === 1'b1) obs_accepted = 1'b1;
            @(posedge clk); #1;
        end
        bus.cmd_valid = 1'b0; bus.cmd_write = ~wr; bus.cmd_addr = 8'hEE;
        bus.cmd_wdata = 32'h0BAD_F00D; bus.cmd_strb = 4'h5;
        acc = 0;
        if (obs_accepted) begin
            for (int cyc = 1; cyc <= limit && obs_lat < 0; cyc++) begin
                if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
                    bus.PREADY  = (acc == waits);
                    bus.PSLVERR = slverr && (acc == waits);
                    bus.PRDATA  = (acc == waits) ? rdata : (32'hDEAD_0000 + 32'(acc));
                    if (bus.PADDR !== addr || bus.PWRITE !== wr || bus.PWDATA !== ewd || bus.PSTRB !== est)
                        obs_stable_ok = 1'b0;
                    acc++;
                end else begin
                    idle_slave();
                end
                if (cyc == 1)
                    obs_setup_ok = (bus.PSEL === 1'b1 && bus.PENABLE === 1'b0 && bus.PADDR === addr &&
                                    bus.PWRITE === wr && bus.PWDATA === ewd && bus.PSTRB === est);
                @(negedge clk);
                if (bus.rsp_valid === 1'b1) begin
                    obs_lat = cyc;
                    obs_rsp = '{rdata: bus.rsp_rdata, err: bus.rsp_err, timeout: bus.rsp_timeout};
                    obs_rdy_at_rsp = bus.cmd_ready;
                end else if (bus.cmd_ready !== 1'b0) begin
                    obs_busy_ready = 1'b1;
                end
                @(posedge clk); #1;
            end
        end
        obs_acc = acc;
        idle_slave();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_strb = '0;
        idle_slave();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {bus.PSEL, bus.PENABLE, bus.cmd_ready, bus.rsp_valid});
        end
        checks++;
        if ({bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB} !== 45'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0", {bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB});
        end
        checks++;
        if ({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== 34'h0) begin
            errors++;
            $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.PSEL} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got ready/psel %b expected 10", {bus.cmd_ready, bus.PSEL});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_zero_wait();
        xfer(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h55AA55AA, 10);
        checks++;
        if (!(obs_accepted && obs_setup_ok)) begin
            errors++;
            $display("FAIL wr_setup: got accepted=%b setup_ok=%b expected 1 1", obs_accepted, obs_setup_ok);
        end
        checks++;
        if (obs_lat !== 3 || obs_acc !== 1 || !obs_stable_ok) begin
            errors++;
            $display("FAIL wr_latency: got lat=%0d access=%0d stable=%b expected 3 1 1", obs_lat, obs_acc, obs_stable_ok);
        end
        checks++;
        if (obs_rsp !== apb_rsp_t'{rdata: 32'h0, err: 1'b0, timeout: 1'b0}) begin
            errors++;
            $display("FAIL wr_rsp: got %h expected %h", obs_rsp, apb_rsp_t'{rdata: 32'h0, err: 1'b0, timeout: 1'b0});
        end
        checks++;
        if (obs_busy_ready !== 1'b0 || obs_rdy_at_rsp !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready: got busy_ready=%b ready_at_rsp=%b expected 0 1", obs_busy_ready, obs_rdy_at_rsp);
        end
        @(negedge clk);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB} !== {2'b00, 8'h10, 1'b1, 32'hDEADBEEF, 4'hF}) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h", {bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWRITE, bus.PWDATA, bus.PSTRB},
                     {2'b00, 8'h10, 1'b1, 32'hDEADBEEF, 4'hF});
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_one_cycle: got rsp_valid=%b expected 0", bus.rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_read_wait();
        xfer(1'b0, 8'h10, 32'h1111_2222, 4'hF, 4, 1'b0, 32'hDEADBEEF, 20);
        checks++;
        if (!(obs_accepted && obs_setup_ok)) begin
            errors++;
            $display("FAIL rd_setup: got accepted=%b setup_ok=%b expected 1 1", obs_accepted, obs_setup_ok);
        end
        checks++;
        if (obs_lat !== 7 || obs_acc !== 5 || !obs_stable_ok) begin
            errors++;
            $display("FAIL rd_wait: got lat=%0d access=%0d stable=%b expected 7 5 1", obs_lat, obs_acc, obs_stable_ok);
        end
        checks++;
        if (obs_rsp !== apb_rsp_t'{rdata: 32'hDEADBEEF, err: 1'b0, timeout: 1'b0}) begin
            errors++;
            $display("FAIL rd_rsp: got %h expected %h", obs_rsp, apb_rsp_t'{rdata: 32'hDEADBEEF, err: 1'b0, timeout: 1'b0});
        end
    endtask

    task automatic test_slverr();
        xfer(1'b1, 8'hC0, 32'h0000_00FF, 4'h3, 1, 1'b1, 32'h0, 10);
        checks++;
        if (obs_lat !== 4 || obs_rsp !== apb_rsp_t'{rdata: 32'h0, err: 1'b1, timeout: 1'b0}) begin
            errors++;
            $display("FAIL wr_slverr: got lat=%0d rsp=%h expected 4 %h", obs_lat, obs_rsp, apb_rsp_t'{rdata: 32'h0, err: 1'b1, timeout: 1'b0});
        end
        xfer(1'b0, 8'hC0, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 32'h1234_5678, 10);
        checks++;
        if (obs_lat !== 3 || obs_rsp !== apb_rsp_t'{rdata: 32'h1234_5678, err: 1'b1, timeout: 1'b0}) begin
            errors++;
            $display("FAIL rd_slverr: got lat=%0d rsp=%h expected 3 %h", obs_lat, obs_rsp, apb_rsp_t'{rdata: 32'h1234_5678, err: 1'b1, timeout: 1'b0});
        end
        checks++;
        if (!(obs_setup_ok && obs_stable_ok)) begin
            errors++;
            $display("FAIL rd_strb_zero: got setup_ok=%b stable=%b expected 1 1", obs_setup_ok, obs_stable_ok);
        end
    endtask

    task automatic test_strb_zero();
        xfer(1'b1, 8'h20, 32'h0102_0304, 4'h0, 0, 1'b0, 32'h0, 10);
        checks++;
        if (obs_lat !== 3 || obs_acc !== 1 || !obs_setup_ok || !obs_stable_ok) begin
            errors++;
            $display("FAIL wr_strb0: got lat=%0d access=%0d setup=%b stable=%b expected 3 1 1 1",
                     obs_lat, obs_acc, obs_setup_ok, obs_stable_ok);
        end
    endtask

    task automatic test_reset_abort();
        int rsp_seen;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 8'h30;
        bus.cmd_wdata = 32'hCAFE_0001; bus.cmd_strb = 4'hF;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b expected 1", bus.cmd_ready);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL abort_access: got psel/penable %b expected 11", {bus.PSEL, bus.PENABLE});
        end
        rst = 1'b1;
        bus.PREADY = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_drop: got %b expected 0000", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready});
        end
        rsp_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) rsp_seen++;
        end
        checks++;
        if (rsp_seen !== 0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_no_rsp: got rsp_cycles=%0d ready=%b expected 0 1", rsp_seen, bus.cmd_ready);
        end
        @(posedge clk); #1;
        xfer(1'b0, 8'h34, 32'h0, 4'h0, 0, 1'b0, 32'h0BEE_F00D, 10);
        checks++;
        if (obs_lat !== 3 || obs_rsp !== apb_rsp_t'{rdata: 32'h0BEE_F00D, err: 1'b0, timeout: 1'b0}) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d rsp=%h expected 3 %h", obs_lat, obs_rsp, apb_rsp_t'{rdata: 32'h0BEE_F00D, err: 1'b0, timeout: 1'b0});
        end
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 8'h40, 32'h0, 4'h0, 1000, 1'b0, 32'h77, 40);
        checks++;
        if (obs_lat !== 18 || obs_acc !== 16 || obs_rsp !== apb_rsp_t'{rdata: 32'h0, err: 1'b1, timeout: 1'b1}) begin
            errors++;
            $display("FAIL timeout_abort: got lat=%0d access=%0d rsp=%h expected 18 16 %h", obs_lat, obs_acc, obs_rsp,
                     apb_rsp_t'{rdata: 32'h0, err: 1'b1, timeout: 1'b1});
        end
        xfer(1'b0, 8'h44, 32'h0, 4'h0, 15, 1'b0, 32'hCAFE_F00D, 40);
        checks++;
        if (obs_lat !== 18 || obs_acc !== 16 || obs_rsp !== apb_rsp_t'{rdata: 32'hCAFE_F00D, err: 1'b0, timeout: 1'b0}) begin
            errors++;
            $display("FAIL timeout_ready_wins: got lat=%0d access=%0d rsp=%h expected 18 16 %h", obs_lat, obs_acc, obs_rsp,
                     apb_rsp_t'{rdata: 32'hCAFE_F00D, err: 1'b0, timeout: 1'b0});
        end
`else
        xfer(1'b0, 8'h40, 32'h0, 4'h0, 20, 1'b0, 32'h77, 40);
        checks++;
        if (obs_lat !== 23 || obs_acc !== 21 || obs_rsp !== apb_rsp_t'{rdata: 32'h77, err: 1'b0, timeout: 1'b0}) begin
            errors++;
            $display("FAIL long_wait: got lat=%0d access=%0d rsp=%h expected 23 21 %h", obs_lat, obs_acc, obs_rsp,
                     apb_rsp_t'{rdata: 32'h77, err: 1'b0, timeout: 1'b0});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slverr();
        test_strb_zero();
        test_reset_abort();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
